// File: rtl/fdiv_mant_iter_pkg.sv
// Shared FPU divider definitions: FSM state encoding, quotient/counter width
// derivation and standard significand widths.
// Ports: none (package).
package fdiv_mant_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // IEEE significand widths including the hidden bit.
  localparam int W_DOUBLE = 53;
  localparam int W_SINGLE = 24;

  // Quotient bits: one integer bit plus W+1 fraction bits (guard and round
  // land below the W-bit result).
  function automatic int qbits_f(input int w);
    return w + 2;
  endfunction

  // Counter must be able to hold QBITS.
  function automatic int cw_f(input int w);
    return $clog2(w + 3);
  endfunction

endpackage

// File: rtl/fdiv_mant_iter_step.sv
// One radix-2 restoring iteration: subtract divisor, test sign, pick the
// shifted difference or the shifted partial remainder. Purely combinational.
// Ports: rem/div (W+2 bits) in; rem_next (W+2 bits), qbit out.
module fdiv_mant_iter_step
  import fdiv_mant_iter_pkg::*;
#(
  parameter int W = W_DOUBLE
) (
  input  logic [W+1:0] rem,
  input  logic [W+1:0] div,
  output logic [W+1:0] rem_next,
  output logic         qbit
);

  logic [W+1:0] diff;

  // rem < 2*div holds throughout, so a non-negative difference never reaches
  // bit W+1 and a negative one always sets it: bit W+1 is a clean sign.
  assign diff     = rem - div;
  assign qbit     = ~diff[W+1];
  assign rem_next = qbit ? {diff[W:0], 1'b0} : {rem[W:0], 1'b0};

endmodule

// File: rtl/fdiv_mant_iter.sv
// Iterative radix-2 restoring significand divider, one quotient bit per cycle.
// Ports: clk, reset_n, start/flush in; x/d operands (W bits) in;
//        ready/busy/done status out; q (QBITS), sticky, dz results out.
module fdiv_mant_iter
  import fdiv_mant_iter_pkg::*;
#(
  parameter  int W     = W_DOUBLE,
  localparam int QBITS = qbits_f(W),
  localparam int CW    = cw_f(W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     d,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [QBITS-1:0] q,
  output logic             sticky,
  output logic             dz
);

  state_t        state;
  logic [W+1:0]  rem;
  logic [W+1:0]  div;
  logic [CW-1:0] count;
  logic [W+1:0]  rem_next;
  logic          qbit;

  fdiv_mant_iter_step #(.W(W)) u_step (
    .rem      (rem),
    .div      (div),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // DONE also accepts a new op so results can stream back-to-back.
  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == ITER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rem    <= '0;
      div    <= '0;
      count  <= '0;
      q      <= '0;
      sticky <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Abort wins over everything, including a same-cycle start.
        state  <= IDLE;
        q      <= '0;
        sticky <= 1'b0;
        dz     <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              if (d == '0) begin
                // Divide by zero skips iteration entirely.
                state  <= DONE;
                done   <= 1'b1;
                q      <= '1;
                sticky <= 1'b0;
                dz     <= 1'b1;
              end else begin
                state  <= ITER;
                rem    <= {2'b00, x};
                div    <= {2'b00, d};
                q      <= '0;
                count  <= '0;
                sticky <= 1'b0;
                dz     <= 1'b0;
              end
            end else begin
              state <= IDLE;
            end
          end
          ITER: begin
            rem   <= rem_next;
            q     <= {q[QBITS-2:0], qbit};
            count <= count + 1'b1;
            if (count == CW'(QBITS - 1)) begin
              sticky <= |rem_next;
              state  <= DONE;
              done   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fdiv_mant_iter.sv
// Directed bench for fdiv_mant_iter at W=4 and W=53, plus a W=53 sweep
// against a wide-integer quotient model.
module tb_fdiv_mant_iter;

  logic clk;
  logic reset_n;

  // W=4 instance
  logic       start4, flush4;
  logic [3:0] x4, d4;
  logic       ready4, busy4, done4, sticky4, dz4;
  logic [5:0] q4;

  // W=53 instance
  logic        start53, flush53;
  logic [52:0] x53, d53;
  logic        ready53, busy53, done53, sticky53, dz53;
  logic [54:0] q53;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  fdiv_mant_iter #(.W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .flush(flush4),
    .x(x4), .d(d4), .ready(ready4), .busy(busy4), .done(done4),
    .q(q4), .sticky(sticky4), .dz(dz4)
  );

  fdiv_mant_iter #(.W(53)) dut53 (
    .clk(clk), .reset_n(reset_n), .start(start53), .flush(flush53),
    .x(x53), .d(d53), .ready(ready53), .busy(busy53), .done(done53),
    .q(q53), .sticky(sticky53), .dz(dz53)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a W=4 op and return the cycle number done appears in (start edge = 0).
  task automatic run4(input logic [3:0] xv, input logic [3:0] dv, output int lat);
    x4 = xv; d4 = dv; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run53(input logic [52:0] xv, input logic [52:0] dv, output int lat);
    x53 = xv; d53 = dv; start53 = 1'b1;
    tick();
    start53 = 1'b0;
    lat = 1;
    while (!done53 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int saw_done;
    logic [63:0]  r;
    logic [106:0] num, qref, rref;
    logic [52:0]  xv, dv;

    reset_n = 1'b0;
    start4 = 0; flush4 = 0; x4 = 0; d4 = 0;
    start53 = 0; flush53 = 0; x53 = 0; d53 = 0;
    #2;
    check("rst_ready4", ready4, 1);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_q4", q4, 0);
    check("rst_sticky4", sticky4, 0);
    check("rst_dz4", dz4, 0);
    check("rst_q53", q53, 0);
    check("rst_ready53", ready53, 1);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // x == d: exact quotient 1.0
    run4(4'b1000, 4'b1000, lat);
    check("eq_lat", lat, 7);
    check("eq_q", q4, 6'b100000);
    check("eq_sticky", sticky4, 0);
    check("eq_dz", dz4, 0);
    tick();
    check("eq_done_pulse", done4, 0);
    check("eq_q_hold", q4, 6'b100000);

    // 1 / 1.5: inexact
    run4(4'b1000, 4'b1100, lat);
    check("tt_lat", lat, 7);
    check("tt_q", q4, 6'b010101);
    check("tt_sticky", sticky4, 1);

    // 1.875 / 1, then back-to-back start in the DONE cycle
    run4(4'b1111, 4'b1000, lat);
    check("big_q", q4, 6'b111100);
    check("big_sticky", sticky4, 0);
    check("b2b_ready_in_done", ready4, 1);
    run4(4'b1000, 4'b1100, lat);
    check("b2b_lat", lat, 7);
    check("b2b_q", q4, 6'b010101);
    check("b2b_sticky", sticky4, 1);
    tick();

    // divide by zero
    run4(4'b1010, 4'b0000, lat);
    check("dz_lat", lat, 1);
    check("dz_dz", dz4, 1);
    check("dz_q", q4, 6'b111111);
    check("dz_sticky", sticky4, 0);
    tick();

    // start pulsed mid-op is ignored; operands change freely afterwards
    x4 = 4'b1000; d4 = 4'b1100; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("ign_dz_cleared", dz4, 0);
    tick();
    check("ign_busy", busy4, 1);
    check("ign_ready", ready4, 0);
    x4 = 4'b1111; d4 = 4'b0000; start4 = 1'b1;
    tick();
    start4 = 1'b0; x4 = 4'b0001; d4 = 4'b0011;
    lat = 3;
    while (!done4 && lat < 100) begin
      tick();
      lat++;
    end
    check("ign_lat", lat, 7);
    check("ign_q", q4, 6'b010101);
    check("ign_dz", dz4, 0);
    tick();

    // W=53 directed: exact 1.0 -> q = 2^54
    xv = 53'd1 << 52;
    run53(xv, xv, lat);
    check("w53_lat", lat, 56);
    check("w53_eq_q", q53, 64'd1 << 54);
    check("w53_eq_sticky", sticky53, 0);
    tick();

    // W=53 flush during cycle 20
    x53 = {1'b1, 52'h5_5555_5555_5555}; d53 = {1'b1, 52'hA_BCDE_F012_3456};
    start53 = 1'b1;
    tick();
    start53 = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    flush53 = 1'b1;
    tick();
    flush53 = 1'b0;
    check("fl_ready", ready53, 1);
    check("fl_busy", busy53, 0);
    check("fl_done", done53, 0);
    check("fl_q", q53, 0);
    saw_done = 0;
    for (int i = 0; i < 70; i++) begin
      if (done53) saw_done = 1;
      tick();
    end
    check("fl_no_done", saw_done, 0);

    // W=53 async reset at cycle 30
    x53 = {1'b1, 52'h1_2345_6789_ABCD}; d53 = {1'b1, 52'h0_0000_0000_0001};
    start53 = 1'b1;
    tick();
    start53 = 1'b0;
    for (int i = 1; i < 30; i++) tick();
    check("ar_busy_before", busy53, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_ready", ready53, 1);
    check("ar_busy", busy53, 0);
    check("ar_done", done53, 0);
    check("ar_q", q53, 0);
    check("ar_sticky", sticky53, 0);
    check("ar_dz", dz53, 0);
    #1;
    reset_n = 1'b1;
    tick();

    // W=53 sweep against floor(x*2^54/d)
    for (int n = 0; n < 200; n++) begin
      r  = {$urandom, $urandom};
      xv = {1'b1, r[51:0]};
      r  = {$urandom, $urandom};
      dv = {1'b1, r[51:0]};
      if (n == 0) xv = '1;
      if (n == 1) dv = '1;
      num  = {xv, 54'b0};
      qref = num / {54'b0, dv};
      rref = num % {54'b0, dv};
      run53(xv, dv, lat);
      check("rnd_lat", lat, 56);
      check("rnd_q", q53, qref[63:0]);
      check("rnd_sticky", sticky53, (rref != 0) ? 64'd1 : 64'd0);
      check("rnd_dz", dz53, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
